// File: rtl/mfcc_feature_buffer.sv
// Sliding window of the most recent MFCC frames, rescaled to saturated Q15 words,
// replayed oldest-first to the keyword classifier over a valid/ready stream.
//   state  | meaning
//   IDLE   | collecting frames, waiting for a pending start with a full window
//   ARM    | latch oldest frame, issue first RAM read
//   STREAM | emitting the window; incoming frames are dropped whole
module mfcc_feature_buffer #(
   parameter int NUM_COEFFS = 13,
   parameter int NUM_FRAMES = 49,
   parameter int FRAC_SHIFT = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_mfcc_in,
   input  logic        i_mfcc_in_valid,
   input  logic        i_flush,
   input  logic        i_start,
   output logic [15:0] o_feat_out,
   output logic        o_feat_valid,
   input  logic        i_feat_ready,
   output logic        o_feat_last,
   output logic        o_window_full,
   output logic        o_busy,
   output logic        o_frame_dropped
);
   localparam int DEPTH = NUM_COEFFS * NUM_FRAMES;
   localparam int CW    = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1;
   localparam int FW    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int SW    = $clog2(NUM_FRAMES + 1);
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW    = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_STREAM} state_t;

   state_t              r_state, w_state_nxt;
   logic                w_clr, w_arm, w_streaming, w_window_full;
   logic signed [31:0]  w_shifted;
   logic [15:0]         w_sat;
   logic [CW-1:0]       r_coeff_idx;
   logic [FW-1:0]       r_wr_frame;
   logic [SW-1:0]       r_frames_stored;
   logic                r_drop_frame, r_frame_dropped, r_start_pending;
   logic                w_coeff_first, w_coeff_last, w_dropping, w_wr_en;
   logic [AW-1:0]       w_wr_addr, w_rd_addr;
   logic [15:0]         r_mem [DEPTH];
   logic [FW-1:0]       r_rd_frame, w_rd_frame_cur;
   logic [CW-1:0]       r_rd_coeff, w_rd_coeff_cur;
   logic [NW-1:0]       r_rd_cnt, w_rd_cnt_cur;
   logic                w_out_en, w_rd_issue;
   logic [15:0]         r_s1_data, r_feat_out;
   logic                r_s1_valid, r_s1_last, r_feat_valid, r_feat_last;

   assign w_clr = i_rst | i_flush;

   assign w_shifted = $signed(i_mfcc_in) >>> FRAC_SHIFT;
   always_comb begin
      w_sat = w_shifted[15:0];
      if (w_shifted > 32'sd32767)       w_sat = 16'h7FFF;
      else if (w_shifted < -32'sd32768) w_sat = 16'h8000;
   end

   // A frame is accepted or dropped as a unit, decided on its first coefficient.
   assign w_coeff_first = (r_coeff_idx == '0);
   assign w_coeff_last  = (r_coeff_idx == CW'(NUM_COEFFS - 1));
   assign w_dropping    = w_coeff_first ? (r_state != S_IDLE) : r_drop_frame;
   assign w_wr_en       = i_mfcc_in_valid && !w_dropping && !w_clr;
   assign w_wr_addr     = AW'(int'(r_wr_frame) * NUM_COEFFS + int'(r_coeff_idx));
   assign w_window_full = (r_frames_stored == SW'(NUM_FRAMES));

   always_ff @(posedge i_clk) begin
      if (w_clr) begin
         r_coeff_idx     <= '0;
         r_wr_frame      <= '0;
         r_frames_stored <= '0;
         r_drop_frame    <= 1'b0;
         r_frame_dropped <= 1'b0;
      end else begin
         r_frame_dropped <= 1'b0;
         if (i_mfcc_in_valid) begin
            r_drop_frame <= w_dropping;
            if (w_coeff_last) begin
               r_coeff_idx <= '0;
               if (w_dropping) begin
                  r_frame_dropped <= 1'b1;
               end else begin
                  r_wr_frame <= (r_wr_frame == FW'(NUM_FRAMES - 1)) ? '0 : r_wr_frame + 1'b1;
                  if (!w_window_full) r_frames_stored <= r_frames_stored + 1'b1;
               end
            end else begin
               r_coeff_idx <= r_coeff_idx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr_en)    r_mem[w_wr_addr] <= w_sat;
      if (w_rd_issue) r_s1_data <= r_mem[w_rd_addr];
   end

   always_ff @(posedge i_clk) begin
      if (w_clr)                              r_start_pending <= 1'b0;
      else if (w_arm)                         r_start_pending <= 1'b0;
      else if (i_start && r_state == S_IDLE)  r_start_pending <= 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (w_clr) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (r_start_pending && w_window_full && w_coeff_first && !i_mfcc_in_valid)
                      w_state_nxt = S_ARM;
         S_ARM:    w_state_nxt = S_STREAM;
         S_STREAM: if (r_feat_valid && i_feat_ready && r_feat_last) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_arm       = (r_state == S_ARM);
      w_streaming = (r_state == S_STREAM);
      o_busy      = r_start_pending || (r_state != S_IDLE);
   end

   // The RAM output register doubles as the prefetch slot ahead of the output register.
   assign w_rd_frame_cur = w_arm ? r_wr_frame : r_rd_frame;
   assign w_rd_coeff_cur = w_arm ? '0 : r_rd_coeff;
   assign w_rd_cnt_cur   = w_arm ? '0 : r_rd_cnt;
   assign w_out_en       = !r_feat_valid || i_feat_ready;
   assign w_rd_issue     = !w_clr && (w_arm || (w_streaming && r_rd_cnt != NW'(DEPTH)
                                                && (!r_s1_valid || w_out_en)));
   assign w_rd_addr      = AW'(int'(w_rd_frame_cur) * NUM_COEFFS + int'(w_rd_coeff_cur));

   always_ff @(posedge i_clk) begin
      if (w_clr) begin
         r_rd_frame <= '0;
         r_rd_coeff <= '0;
         r_rd_cnt   <= '0;
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
      end else begin
         if (w_rd_issue) begin
            r_rd_cnt   <= w_rd_cnt_cur + 1'b1;
            r_s1_valid <= 1'b1;
            r_s1_last  <= (w_rd_cnt_cur == NW'(DEPTH - 1));
            if (w_rd_coeff_cur == CW'(NUM_COEFFS - 1)) begin
               r_rd_coeff <= '0;
               r_rd_frame <= (w_rd_frame_cur == FW'(NUM_FRAMES - 1)) ? '0 : w_rd_frame_cur + 1'b1;
            end else begin
               r_rd_coeff <= w_rd_coeff_cur + 1'b1;
               r_rd_frame <= w_rd_frame_cur;
            end
         end else if (r_s1_valid && w_out_en) begin
            r_s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_clr) begin
         r_feat_out   <= '0;
         r_feat_valid <= 1'b0;
         r_feat_last  <= 1'b0;
      end else if (w_out_en) begin
         r_feat_valid <= r_s1_valid;
         r_feat_last  <= r_s1_valid && r_s1_last;
         if (r_s1_valid) r_feat_out <= r_s1_data;
      end
   end

   assign o_feat_out      = r_feat_out;
   assign o_feat_valid    = r_feat_valid;
   assign o_feat_last     = r_feat_last;
   assign o_window_full   = w_window_full;
   assign o_frame_dropped = r_frame_dropped;
endmodule

// File: tb/tb_mfcc_feature_buffer.sv
// Directed bench for mfcc_feature_buffer: fill/readout, drop, backpressure,
// wrap-around, saturation, flush mid-stream and early start.
module tb_mfcc_feature_buffer;
   localparam int NC    = 13;
   localparam int NF    = 49;
   localparam int TOTAL = NC * NF;

   logic        i_clk = 1'b0;
   logic        i_rst, i_mfcc_in_valid, i_flush, i_start, i_feat_ready;
   logic [31:0] i_mfcc_in;
   logic [15:0] o_feat_out;
   logic        o_feat_valid, o_feat_last, o_window_full, o_busy, o_frame_dropped;

   int total = 0;
   int bad   = 0;
   int n_fed = 0;
   logic [15:0] mdl [0:63][0:NC-1];
   logic [31:0] fr_raw [0:NC-1];
   logic [15:0] fr_exp [0:NC-1];
   logic [15:0] fw, lw;
   int early_v, no_busy;

   mfcc_feature_buffer #(.NUM_COEFFS(NC), .NUM_FRAMES(NF), .FRAC_SHIFT(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_mfcc_in(i_mfcc_in), .i_mfcc_in_valid(i_mfcc_in_valid),
      .i_flush(i_flush), .i_start(i_start), .o_feat_out(o_feat_out), .o_feat_valid(o_feat_valid),
      .i_feat_ready(i_feat_ready), .o_feat_last(o_feat_last), .o_window_full(o_window_full),
      .o_busy(o_busy), .o_frame_dropped(o_frame_dropped)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame();
      for (int k = 0; k < NC; k++) begin
         i_mfcc_in       = fr_raw[k];
         i_mfcc_in_valid = 1'b1;
         tick();
      end
      i_mfcc_in_valid = 1'b0;
      for (int k = 0; k < NC; k++) mdl[n_fed][k] = fr_exp[k];
      n_fed++;
   endtask

   task automatic send_pattern(input int f);
      for (int k = 0; k < NC; k++) begin
         fr_raw[k] = 32'(((f << 8) + k) << 8);
         fr_exp[k] = 16'((f << 8) + k);
      end
      send_frame();
   endtask

   task automatic read_window(input bit do_start, input bit rnd, input int inject_off,
                              input int flush_word, input bit check_lat,
                              output logic [15:0] first_w, output logic [15:0] last_w);
      int got = 0, cyc = 0, first_cyc = -1, bubbles = 0, inj = -1, base;
      bit seen_last = 0, stalled = 0, aborted = 0;
      logic [15:0] hold_d, exp_w;
      logic hold_l;
      base    = n_fed - NF;
      first_w = '0;
      last_w  = '0;
      hold_d  = '0;
      hold_l  = 1'b0;
      if (do_start) begin
         i_start = 1'b1;
         tick();
         i_start = 1'b0;
         check("busy_after_start", 32'(o_busy), 32'd1);
      end
      i_feat_ready = 1'b1;
      while (!seen_last && cyc < 5000) begin
         tick();
         cyc++;
         if (flush_word >= 0 && got == flush_word) begin
            i_flush = 1'b1;
            tick();
            i_flush = 1'b0;
            check("flush_valid", 32'(o_feat_valid), 32'd0);
            check("flush_last", 32'(o_feat_last), 32'd0);
            check("flush_full", 32'(o_window_full), 32'd0);
            check("flush_busy", 32'(o_busy), 32'd0);
            aborted = 1;
            break;
         end
         if (stalled) begin
            check("stall_valid", 32'(o_feat_valid), 32'd1);
            check("stall_data", 32'(o_feat_out), 32'(hold_d));
            check("stall_last", 32'(o_feat_last), 32'(hold_l));
         end
         if (o_feat_valid && first_cyc < 0) first_cyc = cyc;
         else if (first_cyc >= 0 && !o_feat_valid) bubbles++;
         if (inj == 13) begin
            check("frame_dropped", 32'(o_frame_dropped), 32'd1);
            i_mfcc_in_valid = 1'b0;
            inj = 14;
         end
         if (inj < 0 && inject_off >= 0 && first_cyc >= 0 && cyc == first_cyc + inject_off) inj = 0;
         if (inj >= 0 && inj < 13) begin
            i_mfcc_in       = 32'h0055_5500 + 32'(inj);
            i_mfcc_in_valid = 1'b1;
            inj++;
         end
         i_feat_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (o_feat_valid && i_feat_ready) begin
            exp_w = mdl[base + got / NC][got % NC];
            check($sformatf("word%0d", got), 32'(o_feat_out), 32'(exp_w));
            check($sformatf("last%0d", got), 32'(o_feat_last), 32'(got == TOTAL - 1));
            if (got == 0) first_w = o_feat_out;
            last_w = o_feat_out;
            if (o_feat_last) seen_last = 1;
            got++;
         end
         stalled = o_feat_valid && !i_feat_ready;
         hold_d  = o_feat_out;
         hold_l  = o_feat_last;
      end
      if (!aborted) begin
         check("stream_done", 32'(seen_last), 32'd1);
         check("word_count", 32'(got), 32'(TOTAL));
         if (!rnd) check("bubbles", 32'(bubbles), 32'd0);
         if (check_lat) check("first_latency", 32'(first_cyc), 32'd3);
         tick();
         check("busy_after_end", 32'(o_busy), 32'd0);
         check("valid_after_end", 32'(o_feat_valid), 32'd0);
      end
      i_feat_ready = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1; i_mfcc_in = '0; i_mfcc_in_valid = 1'b0;
      i_flush = 1'b0; i_start = 1'b0; i_feat_ready = 1'b0;
      tick(); tick();
      i_rst = 1'b0;
      check("rst_out", 32'(o_feat_out), 32'd0);
      check("rst_valid", 32'(o_feat_valid), 32'd0);
      check("rst_last", 32'(o_feat_last), 32'd0);
      check("rst_full", 32'(o_window_full), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_dropped", 32'(o_frame_dropped), 32'd0);

      // fill exactly one window, then read with ready held high
      for (int f = 0; f < NF - 1; f++) send_pattern(f);
      check("full_before_last", 32'(o_window_full), 32'd0);
      send_pattern(NF - 1);
      check("full_after_last", 32'(o_window_full), 32'd1);
      read_window(1, 0, -1, -1, 1, fw, lw);
      check("fill_first", 32'(fw), 32'h0000);
      check("fill_last", 32'(lw), 32'h300C);

      // new frame two cycles into the stream is dropped; window stays intact
      read_window(1, 0, 2, -1, 0, fw, lw);
      check("full_after_drop", 32'(o_window_full), 32'd1);
      check("dropped_cleared", 32'(o_frame_dropped), 32'd0);
      read_window(1, 1, -1, -1, 0, fw, lw);
      check("bp_first", 32'(fw), 32'h0000);
      check("bp_last", 32'(lw), 32'h300C);

      // wrap-around with 52 frames
      i_rst = 1'b1; tick(); i_rst = 1'b0;
      n_fed = 0;
      for (int f = 0; f < 52; f++) send_pattern(f);
      read_window(1, 0, -1, -1, 0, fw, lw);
      check("wrap_first", 32'(fw), 32'h0300);
      check("wrap_last", 32'(lw), 32'h330C);

      // saturation and rounding-boundary vectors as the newest frame
      fr_raw[0]  = 32'h7FFF_FFFF; fr_exp[0]  = 16'h7FFF;
      fr_raw[1]  = 32'h8000_0000; fr_exp[1]  = 16'h8000;
      fr_raw[2]  = 32'hFFFF_FE00; fr_exp[2]  = 16'hFFFE;
      fr_raw[3]  = 32'h0001_2300; fr_exp[3]  = 16'h0123;
      fr_raw[4]  = 32'h007F_FF00; fr_exp[4]  = 16'h7FFF;
      fr_raw[5]  = 32'h0080_0000; fr_exp[5]  = 16'h7FFF;
      fr_raw[6]  = 32'hFF80_0000; fr_exp[6]  = 16'h8000;
      fr_raw[7]  = 32'hFF7F_FF00; fr_exp[7]  = 16'h8000;
      fr_raw[8]  = 32'h0000_00FF; fr_exp[8]  = 16'h0000;
      fr_raw[9]  = 32'hFFFF_FFFF; fr_exp[9]  = 16'hFFFF;
      fr_raw[10] = 32'h1234_5678; fr_exp[10] = 16'h7FFF;
      fr_raw[11] = 32'h0000_1234; fr_exp[11] = 16'h0012;
      fr_raw[12] = 32'hFFFF_8000; fr_exp[12] = 16'hFF80;
      send_frame();
      read_window(1, 0, -1, -1, 0, fw, lw);
      check("sat_first", 32'(fw), 32'h0400);
      check("sat_last", 32'(lw), 32'hFF80);

      // flush at word 100, then flush wins over a simultaneous start
      read_window(1, 0, -1, 100, 0, fw, lw);
      i_flush = 1'b1; i_start = 1'b1;
      tick();
      i_flush = 1'b0; i_start = 1'b0;
      check("flush_beats_start", 32'(o_busy), 32'd0);

      // early start with 10 frames stored waits for the window to fill
      n_fed = 0;
      for (int f = 0; f < 10; f++) send_pattern(f);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("early_busy", 32'(o_busy), 32'd1);
      early_v = 0;
      no_busy = 0;
      for (int f = 10; f < NF; f++) begin
         send_pattern(f);
         if (o_feat_valid) early_v++;
         if (!o_busy) no_busy++;
      end
      check("early_no_output", 32'(early_v), 32'd0);
      check("early_busy_held", 32'(no_busy), 32'd0);
      read_window(0, 0, -1, -1, 0, fw, lw);
      check("early_first", 32'(fw), 32'h0000);
      check("early_last", 32'(lw), 32'h300C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mfcc_feature_buffer.md
# mfcc_feature_buffer

Sliding-window feature store directly downstream of the MFCC accelerator. It consumes the serial `mfcc_out`/`mfcc_valid` coefficient stream, rescales each coefficient to signed 16-bit with saturation, and keeps the most recent NUM_FRAMES frames in a circular buffer. On request it streams the whole window, oldest frame first, to the keyword-spotting classifier over a valid/ready handshake.

## Interface
- NUM_COEFFS, 13, coefficients per frame (matches `num_mfcc_coeffs` programmed into the accelerator)
- NUM_FRAMES, 49, frames held in the window
- FRAC_SHIFT, 8, arithmetic right shift applied before saturation
- clk  in  1  single clock domain, rising edge
- rst  in  1  reset; synchronous, active-high
- mfcc_in  in  32  signed coefficient from the accelerator's `mfcc_out`
- mfcc_in_valid  in  1  one coefficient per asserted cycle; no backpressure
- flush  in  1  synchronous clear of window contents and any stream in progress
- start  in  1  one-cycle pulse requesting a window readout
- feat_out  out  16  signed feature word
- feat_valid  out  1  feat_out holds valid data
- feat_ready  in  1  consumer accepts when feat_valid && feat_ready
- feat_last  out  1  high with the final word of a window
- window_full  out  1  NUM_FRAMES complete frames stored
- busy  out  1  start pending or stream in progress
- frame_dropped  out  1  one-cycle pulse: a full incoming frame was discarded

## Operation
- Conversion: s = mfcc_in >>> FRAC_SHIFT. If s > 32767, the stored value is 0x7FFF. If s < -32768, it is 0x8000. Otherwise it is s[15:0].
- Storage: NUM_COEFFS*NUM_FRAMES x 16 RAM. Address = wr_frame*NUM_COEFFS + coeff_idx.
- coeff_idx counts 0..NUM_COEFFS-1 on each mfcc_in_valid. On wrap, wr_frame advances modulo NUM_FRAMES, and frames_stored increments, saturating at NUM_FRAMES.
- window_full = (frames_stored == NUM_FRAMES).
- Frame-granular drop: a frame whose first coefficient (coeff_idx == 0) arrives while state != IDLE is discarded whole.
  - coeff_idx still counts through the dropped frame.
  - wr_frame and frames_stored are unchanged.
  - frame_dropped pulses on the cycle the dropped frame's last coefficient arrives.
- start latches start_pending. A start arriving while already pending or streaming is ignored.
- FSM states: IDLE, ARM, STREAM.
  - IDLE -> ARM when start_pending && window_full && coeff_idx == 0 && !mfcc_in_valid.
  - If start_pending is set but window_full is low, the request stays pending until the window fills.
  - ARM: latch rd_frame = wr_frame (the oldest frame), clear the read counter, issue the first RAM read, clear start_pending.
  - STREAM: emit NUM_FRAMES*NUM_COEFFS words in frame-major order. Frames run oldest to newest (rd_frame wrapping modulo NUM_FRAMES); coefficients within a frame run 0..NUM_COEFFS-1.
  - STREAM -> IDLE on the handshake of the word that carries feat_last.
- Output holding: feat_out, feat_valid and feat_last come from registers. While feat_valid && !feat_ready, all three hold stable. A one-entry prefetch/skid register sustains one word per cycle under continuous feat_ready.
- flush (and rst):
  - Clears coeff_idx, wr_frame, frames_stored, start_pending and the FSM (to IDLE).
  - Drops feat_valid the next cycle, even mid-stream. No feat_last is produced for an aborted stream.
  - RAM contents need not be cleared.
- Simultaneous flush and start: flush wins and start is discarded.
- Simultaneous mfcc_in_valid and a stream-ending handshake: the state is still STREAM in that cycle, so a first coefficient arriving then is dropped.

## Timing
- Reset values: feat_out=0, feat_valid=0, feat_last=0, window_full=0, busy=0, frame_dropped=0.
- Write path: a coefficient presented at edge N is written at edge N. window_full rises the cycle after the NUM_COEFFS-th coefficient of the NUM_FRAMES-th frame.
- busy rises the cycle after start is sampled and falls the cycle after the final handshake.
- Readout latency: with start sampled at edge N and all IDLE exit conditions met at edge N+1, the FSM is ARM at N+1 and the first feat_valid is high after edge N+3.
- Throughput: with feat_ready held high, one word per cycle and no bubbles. Total NUM_FRAMES*NUM_COEFFS consecutive valid cycles (637 at defaults).
- frame_dropped is registered and asserts the cycle after the dropped frame's last coefficient.

## Test plan
- Fill then read: feed 49 frames with coefficient k of frame f = ((f<<8)+k)<<8, pulse start, hold feat_ready=1. Expect 637 words, word i = ((i/13)<<8)+(i%13), feat_last only on word 636, and no bubbles.
- Wrap-around: feed 52 frames, then start. Expect the first word from frame 3 (0x0300) and the last word from frame 51, coefficient 12 (0x330C).
- Saturation: mfcc_in = 0x7FFF_FFFF → 0x7FFF; 0x8000_0000 → 0x8000; 0xFFFF_FE00 → 0xFFFE; 0x0001_2300 → 0x0123.
- Backpressure: toggle feat_ready pseudo-randomly during readout. Expect feat_out/feat_last stable while stalled and the full ordered sequence with no loss or duplication.
- Drop during stream: begin a new frame two cycles after streaming starts. Expect frame_dropped after its 13th coefficient, window contents unchanged, and the next readout identical to the previous one.
- Flush mid-stream and early start:
  - Assert flush at word 100: feat_valid is low next cycle, and window_full and busy are 0.
  - Then pulse start with only 10 frames stored: busy stays high with no output until frame 49 completes, after which the stream begins.
